// File: rtl/count_display_driver.sv
// Four-digit multiplexed display driver for an up/down counter pair, with a frame-end snapshot.
// Optional leading-zero blanking of the tens digits: define LEADING_ZERO_BLANK_EN.
module count_display_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count_up,
  input  logic [3:0] count_down,
  input  logic       sel,
  input  logic       enable,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] pre_cnt;
  logic [1:0]    idx;
  logic [3:0]    snap_up;
  logic [3:0]    snap_down;
  logic          snap_sel;
  logic          snap_en;
  logic          tick;

  logic [3:0]    val;
  logic [3:0]    digit;
  logic          blank;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = 7'h7F;
    endcase
  endfunction

  assign tick = (pre_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt   <= '0;
      idx       <= 2'd0;
      snap_up   <= 4'd0;
      snap_down <= 4'd0;
      snap_sel  <= 1'b0;
      snap_en   <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) begin
        idx <= idx + 2'd1;
        // Capture only at frame end so every digit of a frame comes from the same values
        if (idx == 2'd3) begin
          snap_up   <= count_up;
          snap_down <= count_down;
          snap_sel  <= sel;
          snap_en   <= enable;
        end
      end
    end
  end

  always_comb begin
    val     = idx[1] ? snap_down : snap_up;
    digit   = 4'd0;
    blank   = 1'b0;
    an_nxt  = 4'b1111;
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;

    if (idx[0]) digit = (val >= 4'd10) ? 4'd1 : 4'd0;
    else        digit = (val >= 4'd10) ? val - 4'd10 : val;

`ifdef LEADING_ZERO_BLANK_EN
    blank = idx[0] && (digit == 4'd0);
`else
    blank = 1'b0;
`endif

    an_nxt[idx] = 1'b0;
    seg_nxt     = blank ? 7'h7F : seg_code(digit);
    // Decimal point marks the tens digit of the active direction
    if (snap_en && ((idx == 2'd1 && !snap_sel) || (idx == 2'd3 && snap_sel)))
      dp_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule
